// File: rtl/rca_response_analyzer.sv
// rca_response_analyzer
// Receiving end of the ripple-carry adder fault-test path. Each valid beat
// (pattern plus adder response) is registered, then compared against the
// golden sum one cycle later. Mismatches are counted (saturating), the first
// failing index is latched, out-of-order indices raise a sticky flag, and
// pass/fail is reported once NUM_PATTERNS beats have been collected.
// Optional feature macro: RCA_MISR_EN (6-bit MISR signature on sig).
module rca_response_analyzer #(
    parameter int WIDTH        = 5,
    parameter int NUM_PATTERNS = 8,
    parameter int ERR_CNT_W    = 4
) (
    input  logic                            clk,
    input  logic                            init,
    input  logic                            start,
    input  logic                            pat_valid,
    input  logic [$clog2(NUM_PATTERNS)-1:0] pat_idx,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic                            c_in,
    input  logic [WIDTH-1:0]                sum,
    input  logic                            c_out,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [ERR_CNT_W-1:0]            err_count,
    output logic [$clog2(NUM_PATTERNS)-1:0] first_fail_idx,
    output logic                            first_fail_valid,
    output logic                            seq_err,
    output logic [5:0]                      sig
);

    localparam int IDX_W = $clog2(NUM_PATTERNS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    // Golden adder result, one bit wider than the operands to hold the carry.
    function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             ci);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    // One MISR shift for polynomial x^6+x+1 with the response folded in.
    function automatic logic [5:0] misr_step(input logic [5:0] s,
                                             input logic [5:0] r);
        return {s[4:0], s[5] ^ s[0]} ^ r;
    endfunction

    logic [1:0]           state_r, state_next_s;
    logic [IDX_W-1:0]     exp_idx_r, exp_idx_next_s;
    logic                 s1_valid_r, s1_valid_next_s;
    logic [IDX_W-1:0]     s1_idx_r;
    logic [WIDTH-1:0]     s1_a_r, s1_b_r;
    logic                 s1_ci_r;
    logic [WIDTH:0]       s1_resp_r;
    logic                 s1_load_s;
    logic                 mis_s;

    logic                 busy_r, busy_next_s;
    logic                 done_r, done_next_s;
    logic                 pass_r, pass_next_s;
    logic [ERR_CNT_W-1:0] err_r, err_next_s;
    logic [IDX_W-1:0]     ffi_r, ffi_next_s;
    logic                 ffv_r, ffv_next_s;
    logic                 seq_r, seq_next_s;
`ifdef RCA_MISR_EN
    logic [5:0]           sig_r, sig_next_s;
`endif

    // Compare stage: flag a mismatch on the registered beat.
    always_comb begin
        mis_s = 1'b0;
        if (s1_valid_r) begin
            mis_s = ({1'b0, s1_resp_r} != {1'b0, golden_sum(s1_a_r, s1_b_r, s1_ci_r)});
        end else begin
            mis_s = 1'b0;
        end
    end

    // Next-state, sampling and result-recording logic.
    always_comb begin
        state_next_s    = state_r;
        exp_idx_next_s  = exp_idx_r;
        s1_valid_next_s = 1'b0;
        s1_load_s       = 1'b0;
        done_next_s     = done_r;
        pass_next_s     = pass_r;
        err_next_s      = err_r;
        ffi_next_s      = ffi_r;
        ffv_next_s      = ffv_r;
        seq_next_s      = seq_r;
`ifdef RCA_MISR_EN
        sig_next_s      = sig_r;
`endif

        // Result recording for the beat sampled last cycle.
        if (s1_valid_r) begin
            if (mis_s) begin
                if (err_r != ERR_MAX) begin
                    err_next_s = err_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    err_next_s = err_r;
                end
                if (!ffv_r) begin
                    ffv_next_s = 1'b1;
                    ffi_next_s = s1_idx_r;
                end else begin
                    ffv_next_s = ffv_r;
                end
            end else begin
                err_next_s = err_r;
            end
`ifdef RCA_MISR_EN
            sig_next_s = misr_step(sig_r, 6'(s1_resp_r));
`endif
        end else begin
            err_next_s = err_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s   = ST_COLLECT;
                    exp_idx_next_s = {IDX_W{1'b0}};
                    done_next_s    = 1'b0;
                    pass_next_s    = 1'b0;
                    err_next_s     = {ERR_CNT_W{1'b0}};
                    ffi_next_s     = {IDX_W{1'b0}};
                    ffv_next_s     = 1'b0;
                    seq_next_s     = 1'b0;
`ifdef RCA_MISR_EN
                    sig_next_s     = 6'h00;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_COLLECT: begin
                if (pat_valid) begin
                    s1_load_s       = 1'b1;
                    s1_valid_next_s = 1'b1;
                    if (pat_idx != exp_idx_r) begin
                        seq_next_s = 1'b1;
                    end else begin
                        seq_next_s = seq_r;
                    end
                    if (exp_idx_r == LAST_IDX) begin
                        exp_idx_next_s = {IDX_W{1'b0}};
                        state_next_s   = ST_DRAIN;
                    end else begin
                        exp_idx_next_s = exp_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    s1_load_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_DONE;
                done_next_s  = 1'b1;
                pass_next_s  = (err_next_s == {ERR_CNT_W{1'b0}}) && !seq_next_s;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        busy_next_s = (state_next_s == ST_COLLECT) || s1_valid_next_s;
    end

    // State, stage-1 pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (init) begin
            state_r    <= ST_IDLE;
            exp_idx_r  <= {IDX_W{1'b0}};
            s1_valid_r <= 1'b0;
            s1_idx_r   <= {IDX_W{1'b0}};
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_ci_r    <= 1'b0;
            s1_resp_r  <= {(WIDTH+1){1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= {ERR_CNT_W{1'b0}};
            ffi_r      <= {IDX_W{1'b0}};
            ffv_r      <= 1'b0;
            seq_r      <= 1'b0;
`ifdef RCA_MISR_EN
            sig_r      <= 6'h00;
`endif
        end else begin
            state_r    <= state_next_s;
            exp_idx_r  <= exp_idx_next_s;
            s1_valid_r <= s1_valid_next_s;
            if (s1_load_s) begin
                s1_idx_r  <= pat_idx;
                s1_a_r    <= a;
                s1_b_r    <= b;
                s1_ci_r   <= c_in;
                s1_resp_r <= {c_out, sum};
            end
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            pass_r     <= pass_next_s;
            err_r      <= err_next_s;
            ffi_r      <= ffi_next_s;
            ffv_r      <= ffv_next_s;
            seq_r      <= seq_next_s;
`ifdef RCA_MISR_EN
            sig_r      <= sig_next_s;
`endif
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_r;
    assign first_fail_idx   = ffi_r;
    assign first_fail_valid = ffv_r;
    assign seq_err          = seq_r;
`ifdef RCA_MISR_EN
    assign sig              = sig_r;
`else
    assign sig              = 6'h00;
`endif

endmodule

// File: tb/tb_rca_response_analyzer.sv
// Scoreboard bench for rca_response_analyzer. Each sweep's expected verdict is
// derived from the adder rules with plain integer arithmetic and queued; a
// monitor pops and compares whenever done rises. A second instance with a
// 2-bit error counter exercises saturation.
module tb_rca_response_analyzer;

    logic       clk = 1'b0;
    logic       init, start, pat_valid, c_in, c_out;
    logic [2:0] pat_idx;
    logic [4:0] a, b, sum;

    logic       busy, done, pass, ffv, seq_err;
    logic [3:0] err_count;
    logic [2:0] ffi;
    logic [5:0] sig;

    logic       busy2, done2, pass2, ffv2, seq_err2;
    logic [1:0] err_count2;
    logic [2:0] ffi2;
    logic [5:0] sig2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pass;
        logic [3:0] err4;
        logic [1:0] err2;
        logic [2:0] ffi;
        logic       ffv;
        logic       seq;
        logic [5:0] sig;
    } exp_t;

    exp_t sb_q[$];
    logic done_seen = 1'b0;

    rca_response_analyzer #(.WIDTH(5), .NUM_PATTERNS(8), .ERR_CNT_W(4)) u_dut (
        .clk(clk), .init(init), .start(start), .pat_valid(pat_valid),
        .pat_idx(pat_idx), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(ffi), .first_fail_valid(ffv), .seq_err(seq_err), .sig(sig)
    );

    rca_response_analyzer #(.WIDTH(5), .NUM_PATTERNS(8), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .init(init), .start(start), .pat_valid(pat_valid),
        .pat_idx(pat_idx), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_fail_idx(ffi2), .first_fail_valid(ffv2), .seq_err(seq_err2), .sig(sig2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic logic [5:0] misr_model(input logic [5:0] s, input logic [5:0] r);
        return {s[4:0], s[5] ^ s[0]} ^ r;
    endfunction

    // Monitor: compare the verdict each time done rises.
    always @(negedge clk) begin
        if (done === 1'b1 && !done_seen) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pass", pass, e.pass);
                chk("err_count", err_count, e.err4);
                chk("first_fail_valid", ffv, e.ffv);
                if (e.ffv) chk("first_fail_idx", ffi, e.ffi);
                chk("seq_err", seq_err, e.seq);
                chk("sig", sig, e.sig);
                chk("done2", done2, 1'b1);
                chk("pass2", pass2, e.pass);
                chk("err_count_sat2", err_count2, e.err2);
                chk("first_fail_idx2", {ffv2, ffi2}, {e.ffv, e.ffv ? e.ffi : ffi2});
                chk("seq_err2", seq_err2, e.seq);
                chk("sig2", sig2, e.sig);
            end
        end
        done_seen = (done === 1'b1);
    end

    task automatic beat(input logic [2:0] idx, input logic [4:0] av, input logic [4:0] bv,
                        input logic cv, input logic [5:0] rv, input logic st);
        pat_valid = 1'b1;
        pat_idx   = idx;
        a         = av;
        b         = bv;
        c_in      = cv;
        {c_out, sum} = rv;
        start     = st;
        @(negedge clk);
        pat_valid = 1'b0;
        start     = 1'b0;
        a         = 5'($urandom);
        b         = 5'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_err"}, err_count, 4'd0);
        chk({tag, "_ffi"}, {ffv, ffi}, 4'd0);
        chk({tag, "_seq"}, seq_err, 1'b0);
        chk({tag, "_sig"}, sig, 6'h00);
        chk({tag, "_err2"}, err_count2, 2'd0);
    endtask

    // mode: 0 good, 1 random faults + gaps + stray start, 2 all wrong,
    // 3 swapped indices, 4 known beat at idx 3 (arg=1 injects stuck sum bit),
    // 5 fixed data good, 6 fixed data with single sum-bit fault;
    // 7 init after 5th beat (no verdict expected)
    task automatic run_sweep(input int mode, input int arg);
        logic [2:0] idx[8];
        logic [4:0] av[8], bv[8];
        logic       cv[8];
        logic [5:0] rv[8];
        logic [5:0] m;
        exp_t       e;
        int         s, errs, nbeats;

        for (int i = 0; i < 8; i++) begin
            idx[i] = 3'(i);
            if (mode == 5 || mode == 6) begin
                av[i] = 5'(i * 3 + 1);
                bv[i] = 5'(i * 5 + 2);
                cv[i] = 1'(i % 2);
            end else begin
                av[i] = 5'($urandom);
                bv[i] = 5'($urandom);
                cv[i] = 1'($urandom);
            end
            s = int'(av[i]) + int'(bv[i]) + int'(cv[i]);
            rv[i] = 6'(s);
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                m = 6'b000001 << $urandom_range(0, 5);
                rv[i] = rv[i] ^ m;
            end
            if (mode == 2) begin
                m = 6'($urandom_range(1, 63));
                rv[i] = rv[i] ^ m;
            end
            if (mode == 6 && i == 5) rv[i] = rv[i] ^ 6'b000001;
            if (mode == 7 && i == 2) rv[i] = rv[i] ^ 6'b000100;
        end
        if (mode == 3) begin
            idx[3] = 3'd4;
            idx[4] = 3'd3;
        end
        if (mode == 4) begin
            av[3] = 5'b10100;
            bv[3] = 5'b10101;
            cv[3] = 1'b1;
            rv[3] = (arg != 0) ? 6'b101000 : 6'b101010;
        end

        // Reference verdict from the adder rules.
        errs  = 0;
        e.ffv = 1'b0;
        e.ffi = 3'd0;
        e.seq = 1'b0;
        e.sig = 6'h00;
        for (int i = 0; i < 8; i++) begin
            s = int'(av[i]) + int'(bv[i]) + int'(cv[i]);
            if (rv[i] != 6'(s)) begin
                errs++;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffi = idx[i];
                end
            end
            if (idx[i] != 3'(i)) e.seq = 1'b1;
`ifdef RCA_MISR_EN
            e.sig = misr_model(e.sig, rv[i]);
`endif
        end
        e.err4 = (errs > 15) ? 4'd15 : 4'(errs);
        e.err2 = (errs > 3) ? 2'd3 : 2'(errs);
        e.pass = (errs == 0) && !e.seq;
        if (mode != 7) sb_q.push_back(e);

        // Stray beat while idle/done must be ignored.
        beat(3'($urandom), 5'($urandom), 5'($urandom), 1'b0, 6'($urandom), 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);

        nbeats = (mode == 7) ? 5 : 8;
        for (int i = 0; i < nbeats; i++) begin
            if (mode == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            beat(idx[i], av[i], bv[i], cv[i], rv[i], (mode == 1 && i == 4));
        end

        if (mode == 7) begin
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
            check_all_zero("init_mid_sweep");
            @(negedge clk);
            check_all_zero("idle_after_init");
        end else begin
            chk("drain_done", done, 1'b0);
            chk("drain_busy", busy, 1'b1);
            @(negedge clk);
            chk("done_latency", done, 1'b1);
            chk("done_busy", busy, 1'b0);
            beat(3'd0, 5'd1, 5'd1, 1'b0, 6'h3f, 1'b0);
            repeat (2) @(negedge clk);
            chk("done_hold", done, 1'b1);
            chk("err_hold", err_count, e.err4);
        end
    endtask

    initial begin
        init = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_idx = 3'd0;
        a = 5'd0; b = 5'd0; c_in = 1'b0; sum = 5'd0; c_out = 1'b0;
        repeat (3) @(negedge clk);
        init = 1'b0;
        check_all_zero("reset");

        run_sweep(0, 0);
        run_sweep(4, 0);
        run_sweep(4, 1);
        run_sweep(2, 0);
        run_sweep(3, 0);
        run_sweep(7, 0);
        run_sweep(0, 0);
        run_sweep(5, 0);
        run_sweep(5, 0);
        run_sweep(6, 0);
        for (int k = 0; k < 25; k++) run_sweep(int'($urandom_range(0, 3)), 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_response_analyzer.md
Name: rca_response_analyzer

Overview:
Output response analyzer for the 5-bit ripple-carry adder fault-test path. It is the receiving end of the test pattern generator. It samples each applied pattern (a, b, c_in, index) together with the adder-under-test's sum and carry-out, and computes the golden result. It counts mismatches, records the first failing pattern index, and reports pass/fail once the full 8-pattern sweep is complete.

Parameters:
WIDTH, 5, operand and sum width of the adder under test
NUM_PATTERNS, 8, patterns per sweep; the index width is clog2(NUM_PATTERNS)
ERR_CNT_W, 4, width of the saturating mismatch counter

Ports:
clk  input  1  rising-edge clock
init  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that arms a new sweep
pat_valid  input  1  the pattern and response inputs are valid this cycle
pat_idx  input  3  pattern index from the generator counter
a  input  WIDTH  operand A applied to the adder under test
b  input  WIDTH  operand B applied to the adder under test
c_in  input  1  carry-in applied to the adder under test
sum  input  WIDTH  sum from the adder under test
c_out  input  1  carry-out from the adder under test
busy  output  1  high while in state COLLECT or while a compare is pending
done  output  1  the sweep is complete; held high until the next start or init
pass  output  1  valid when done; 1 means zero mismatches and no sequence error
err_count  output  ERR_CNT_W  number of mismatching patterns, saturating
first_fail_idx  output  3  pat_idx of the first mismatching pattern
first_fail_valid  output  1  first_fail_idx holds a captured index
seq_err  output  1  sticky flag: a pattern index arrived out of order
sig  output  6  MISR signature (see Optional Feature)

Behaviour:
- Clock, reset and tie-offs:
  - Single clock domain: clk.
  - Reset: synchronous, active-high, signal init.
  - All outputs reset to 0.
  - sig resets to 6'h00.
  - State resets to IDLE.
  - The expected-index counter resets to 0.
- State machine (IDLE, COLLECT, DONE):
  - IDLE: start moves to COLLECT. On the same edge, clear err_count, first_fail_*, seq_err, done, pass and sig, and set the expected index to 0. pat_valid is ignored.
  - COLLECT: each pat_valid beat is sampled into stage-1 registers, and the expected index increments (wrapping at NUM_PATTERNS). When the NUM_PATTERNS-th beat is sampled, move to state DRAIN for one cycle.
  - DRAIN: the last compare completes; then move to DONE.
  - DONE: done=1; pass = (err_count==0) && !seq_err. Outputs hold. start re-arms, with the same clears as in IDLE. pat_valid is ignored.
  - start during COLLECT or DRAIN is ignored.
- Pipeline:
  - A beat presented in cycle N is registered at the end of N.
  - The compare result updates err_count, first_fail_* and sig at the end of N+1, so they are visible in N+2.
  - done and pass are visible 2 cycles after the last beat.
- Arithmetic:
  - expected = a + b + c_in, computed at WIDTH+1 bits.
  - Mismatch when {c_out, sum} != expected.
- Error recording:
  - err_count increments by 1 per mismatch and saturates at all-ones; it never wraps.
  - first_fail_idx and first_fail_valid are captured only on the first mismatch of a sweep.
- Sequence checking:
  - If pat_idx != expected index on a sampled beat, set seq_err. The beat is still compared.
  - Sweep completion counts beats, not index values.
- pat_valid may be non-contiguous; gaps simply stall the sweep.
- init asserted in any state, including mid-sweep with a compare pending, returns the block to reset values on that edge. The pending compare is discarded.

Optional Feature:
- Macro RCA_MISR_EN.
- When defined:
  - A 6-bit MISR with polynomial x^6+x+1 compacts {c_out,sum} on every compare cycle: sig <= {sig[4:0], sig[5]^sig[0]} ^ {c_out,sum}.
  - sig is cleared on init and on start.
  - The signature is final when done is high.
- When not defined: sig is tied to 6'h00 and no MISR logic exists. All other behaviour is identical.

Test Plan:
- Fault-free sweep: start, then 8 beats with idx 0..7 and a correct adder model -> 2 cycles after the last beat, done=1, pass=1, err_count=0, first_fail_valid=0, seq_err=0.
- Beat idx=3, a=5'b10100, b=5'b10101, c_in=1, response sum=5'b01010, c_out=1 -> no error. The same beat with sum bit 1 stuck at 0 (5'b01000) -> err_count=1, first_fail_idx=3, pass=0 at done.
- Every beat wrong, ERR_CNT_W=2, 8 beats -> err_count saturates at 3; first_fail_idx=0.
- Index order 0,1,2,4,3,5,6,7 with correct data -> seq_err=1, pass=0, err_count=0.
- init asserted at the cycle after the 5th beat -> all outputs 0, state IDLE. A following start plus 8 good beats -> pass=1.
- With RCA_MISR_EN defined: two identical fault-free sweeps -> equal nonzero sig. A single-bit sum fault in one beat -> different sig.
